lsu_mem_stage: RTL and testbench

- Parametrised load/store unit for the memory/writeback stage of the MIPS150 pipeline.
- Replaces the fixed 32-bit, single-cycle, big-endian byte masking with a valid/ready request path to the data cache.
- Adds configurable width and endianness, alignment-exception detection, a response timeout, and flush/drain handling.
- Asserts a stall to the pipeline while a memory transaction is outstanding.

---
 rtl/lsu_mem_stage_if.sv | 25 ++
 rtl/lsu_mem_stage.sv | 189 ++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_stage_if.sv
// Data-cache request/response bus between the LSU (master) and the cache (slave).
// No latency of its own; mem_req_valid is held until mem_req_ready, responses are unthrottled.
interface lsu_mem_stage_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_we;
  logic [XLEN/8-1:0]   mem_be;
  logic [ADDR_W-1:0]   mem_addr;
  logic [XLEN-1:0]     mem_wdata;
  logic                mem_rsp_valid;
  logic [XLEN-1:0]     mem_rsp_data;

  modport master (
    output mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// MEM/WB load-store unit: lane-aligns stores, extracts/extends loads; request 1 cycle after accept, wb 1 cycle after rsp.
// Accepts one op at a time (req_ready only in IDLE), holds the cache request until mem_req_ready, stalls the pipe meanwhile.
module lsu_mem_stage #(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  input  logic              flush,
  lsu_mem_stage_if.master   bus,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              stall,
  output logic              exc_misaligned,
  output logic              bus_err,
  output logic [ADDR_W-1:0] exc_addr
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nx;
  logic              cnt_hit;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        rd_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              store_q;
  logic [OB-1:0]     sh_q;

  logic              accept;
  logic              aligned;
  logic              legal;
  logic [3:0]        nb_acc;
  logic [OB-1:0]     off;
  logic [OB-1:0]     sh;
  logic [NB-1:0]     st_be;
  logic [XLEN-1:0]   st_data;
  logic [XLEN-1:0]   raw;
  logic [XLEN-1:0]   ld_mask;
  logic [XLEN-1:0]   ld_data;
  logic              ld_sign;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid & req_ready;
  assign stall     = (state != S_IDLE) | (accept & legal);
  assign cnt_nx    = cnt + CW'(1);
  assign cnt_hit   = (cnt_nx == CW'(TIMEOUT));

  // sh is the lowest lane of the access; BE counts down from the top lane, which
  // wraps cleanly modulo NB because NB is a power of two.
  always_comb begin
    aligned = 1'b1;
    case (req_size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~req_addr[0];
      2'd2:    aligned = (req_addr[1:0] == 2'b00);
      default: aligned = (req_addr[2:0] == 3'b000);
    endcase
    legal   = aligned & ((req_size != 2'd3) | (XLEN == 64));
    nb_acc  = 4'd1 << req_size;
    off     = req_addr[OB-1:0];
    sh      = BIG_ENDIAN ? (OB'(0) - off - OB'(nb_acc)) : off;
    st_be   = ~({NB{1'b1}} << nb_acc);
    st_be   = st_be << sh;
    st_data = req_wdata & ~({XLEN{1'b1}} << {nb_acc, 3'b000});
    st_data = st_data << {sh, 3'b000};
  end

  always_comb begin
    raw     = bus.mem_rsp_data >> {sh_q, 3'b000};
    ld_mask = ~({XLEN{1'b1}} << (32'd8 << size_q));
    ld_sign = 1'b0;
    case (size_q)
      2'd0:    ld_sign = raw[7];
      2'd1:    ld_sign = raw[15];
      2'd2:    ld_sign = raw[31];
      default: ld_sign = raw[XLEN-1];
    endcase
    ld_data = (raw & ld_mask) | ({XLEN{ld_sign & ~uns_q}} & ~ld_mask);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state             <= S_IDLE;
      cnt               <= '0;
      addr_q            <= '0;
      rd_q              <= '0;
      size_q            <= '0;
      uns_q             <= 1'b0;
      store_q           <= 1'b0;
      sh_q              <= '0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_we        <= 1'b0;
      bus.mem_be        <= '0;
      bus.mem_addr      <= '0;
      bus.mem_wdata     <= '0;
      wb_valid          <= 1'b0;
      wb_rd             <= '0;
      wb_data           <= '0;
      exc_misaligned    <= 1'b0;
      bus_err           <= 1'b0;
      exc_addr          <= '0;
    end else begin
      wb_valid       <= 1'b0;
      exc_misaligned <= 1'b0;
      bus_err        <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          if (legal) begin
            addr_q            <= req_addr;
            rd_q              <= req_rd;
            size_q            <= req_size;
            uns_q             <= req_unsigned;
            store_q           <= req_store;
            sh_q              <= sh;
            bus.mem_req_valid <= 1'b1;
            bus.mem_we        <= req_store;
            bus.mem_be        <= st_be;
            bus.mem_addr      <= {req_addr[ADDR_W-1:OB], {OB{1'b0}}};
            bus.mem_wdata     <= st_data;
            state             <= S_REQ;
          end else begin
            exc_misaligned <= 1'b1;
            exc_addr       <= req_addr;
          end
        end
        S_REQ: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            cnt               <= '0;
            if (store_q)    state <= S_IDLE;
            else if (flush) state <= S_DRAIN;
            else            state <= S_WAIT;
          end else if (flush) begin
            bus.mem_req_valid <= 1'b0;
            state             <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (bus.mem_rsp_valid) begin
            state <= S_IDLE;
            if (!flush && rd_q != 5'd0) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
              wb_data  <= ld_data;
            end
          end else begin
            cnt <= cnt_nx;
            // A flush on the expiry cycle is already a drain, so it stays silent.
            if (cnt_hit) begin
              state    <= S_IDLE;
              bus_err  <= ~flush;
              exc_addr <= flush ? exc_addr : addr_q;
            end else if (flush) begin
              state <= S_DRAIN;
            end
          end
        end
        default: begin
          if (bus.mem_rsp_valid) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt_nx;
            if (cnt_hit) state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed and random bench for two lsu_mem_stage builds (32-bit BE, 64-bit LE), both TIMEOUT=8.
// Expected lanes/data come from a per-byte reference model; protocol timing is scripted per op.
module tb_lsu_mem_stage;
  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_store = 1'b0, req_unsigned = 1'b0, flush = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_ready = 1'b0, rsp_valid = 1'b0;
  logic [63:0] rsp_data = '0;

  logic        a_req_ready, a_wb_valid, a_stall, a_exc, a_berr;
  logic [4:0]  a_wb_rd;
  logic [31:0] a_wb_data, a_exc_addr;
  logic        b_req_ready, b_wb_valid, b_stall, b_exc, b_berr;
  logic [4:0]  b_wb_rd;
  logic [63:0] b_wb_data;
  logic [31:0] b_exc_addr;

  logic        o_req_ready, o_mem_vld, o_we, o_wb_valid, o_stall, o_exc, o_berr;
  logic [7:0]  o_be;
  logic [31:0] o_addr, o_exc_addr;
  logic [63:0] o_wdata, o_wb_data;
  logic [4:0]  o_wb_rd;

  int total = 0, bad = 0;
  logic [63:0] last_wb, last_be, last_wd, last_addr;
  logic [4:0]  last_rd;

  lsu_mem_stage_if #(.XLEN(32), .ADDR_W(32)) mif_a ();
  lsu_mem_stage_if #(.XLEN(64), .ADDR_W(32)) mif_b ();

  assign mif_a.mem_req_ready = mem_ready & ~sel;
  assign mif_a.mem_rsp_valid = rsp_valid & ~sel;
  assign mif_a.mem_rsp_data  = rsp_data[31:0];
  assign mif_b.mem_req_ready = mem_ready & sel;
  assign mif_b.mem_rsp_valid = rsp_valid & sel;
  assign mif_b.mem_rsp_data  = rsp_data;

  lsu_mem_stage #(.XLEN(32), .ADDR_W(32), .BIG_ENDIAN(1), .TIMEOUT(8)) dut_a (
    .CLK(CLK), .RST_n(RST_n), .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
    .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_rd(req_rd), .flush(flush & ~sel),
    .bus(mif_a), .wb_valid(a_wb_valid), .wb_rd(a_wb_rd), .wb_data(a_wb_data), .stall(a_stall),
    .exc_misaligned(a_exc), .bus_err(a_berr), .exc_addr(a_exc_addr));

  lsu_mem_stage #(.XLEN(64), .ADDR_W(32), .BIG_ENDIAN(0), .TIMEOUT(8)) dut_b (
    .CLK(CLK), .RST_n(RST_n), .req_valid(req_valid & sel), .req_ready(b_req_ready),
    .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd), .flush(flush & sel),
    .bus(mif_b), .wb_valid(b_wb_valid), .wb_rd(b_wb_rd), .wb_data(b_wb_data), .stall(b_stall),
    .exc_misaligned(b_exc), .bus_err(b_berr), .exc_addr(b_exc_addr));

  always #5 CLK = ~CLK;

  always_comb begin
    o_req_ready = sel ? b_req_ready : a_req_ready;
    o_mem_vld   = sel ? mif_b.mem_req_valid : mif_a.mem_req_valid;
    o_we        = sel ? mif_b.mem_we : mif_a.mem_we;
    o_be        = sel ? mif_b.mem_be : {4'b0, mif_a.mem_be};
    o_addr      = sel ? mif_b.mem_addr : mif_a.mem_addr;
    o_wdata     = sel ? mif_b.mem_wdata : {32'b0, mif_a.mem_wdata};
    o_wb_valid  = sel ? b_wb_valid : a_wb_valid;
    o_wb_rd     = sel ? b_wb_rd : a_wb_rd;
    o_wb_data   = sel ? b_wb_data : {32'b0, a_wb_data};
    o_stall     = sel ? b_stall : a_stall;
    o_exc       = sel ? b_exc : a_exc;
    o_berr      = sel ? b_berr : a_berr;
    o_exc_addr  = sel ? b_exc_addr : a_exc_addr;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte i of an access: BE puts byte 0 (most significant) in lane nb-1-o, LE puts byte 0 (LSB) in lane o.
  function automatic int lane(int nb, bit big, int o, int i);
    return big ? nb - 1 - o - i : o + i;
  endfunction

  function automatic logic [63:0] m_be(int nb, bit big, int o, int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) r[lane(nb, big, o, i)] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] m_wdata(int nb, bit big, int o, int n, logic [63:0] wd);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) begin
      int idx = big ? n - 1 - i : i;
      r[8*lane(nb, big, o, i) +: 8] = wd[8*idx +: 8];
    end
    return r;
  endfunction

  function automatic logic [63:0] m_load(int nb, bit big, int o, int n, bit un, logic [63:0] raw);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) begin
      int idx = big ? n - 1 - i : i;
      v[8*idx +: 8] = raw[8*lane(nb, big, o, i) +: 8];
    end
    if (!un && n < 8 && v[8*n-1]) for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
    if (nb == 4) v[63:32] = '0;
    return v;
  endfunction

  // mode: 0 plain, 1 flush in REQ, 2 flush in WAIT, 3 flush at handshake,
  // 4 flush with response, 5 no response (timeout), 6 flush then no response.
  task automatic run_op(input bit s, input bit st, input logic [1:0] sz, input bit un,
                        input logic [31:0] ad, input logic [63:0] wd, input logic [4:0] rd,
                        input logic [63:0] raw, input int rdy_dly, input int rsp_dly,
                        input int mode, input int fl_dly);
    int nb, n, o;
    bit big, legal, dropped, exp_wb;
    logic [63:0] e_be, e_wd, e_ld, e_addr;
    nb = s ? 8 : 4;
    big = !s;
    n = 1 << sz;
    o = int'(ad[2:0]) % nb;
    legal = (int'(ad[2:0]) % n == 0) && !(sz == 2'd3 && nb == 4);
    e_addr = 64'(ad & ~(32'(nb) - 32'd1));
    @(negedge CLK);
    sel = s; req_store = st; req_size = sz; req_unsigned = un;
    req_addr = ad; req_wdata = wd; req_rd = rd; req_valid = 1'b1;
    #1;
    chk("accept_ready", 64'(o_req_ready), 64'd1);
    chk("accept_stall", 64'(o_stall), 64'(legal));
    @(negedge CLK);
    req_valid = 1'b0;
    if (!legal) begin
      chk("misalign_pulse", 64'(o_exc), 64'd1);
      chk("misalign_addr", 64'(o_exc_addr), 64'(ad));
      chk("misalign_no_req", 64'(o_mem_vld), 64'd0);
      chk("misalign_stall", 64'(o_stall), 64'd0);
      @(negedge CLK);
      chk("misalign_once", 64'(o_exc), 64'd0);
      chk("misalign_no_req2", 64'(o_mem_vld), 64'd0);
      return;
    end
    e_be = m_be(nb, big, o, n);
    e_wd = m_wdata(nb, big, o, n, wd);
    e_ld = m_load(nb, big, o, n, un, raw);
    last_be = 64'(o_be); last_wd = o_wdata; last_addr = 64'(o_addr);
    for (int k = 0; k <= rdy_dly; k++) begin
      if (k > 0) @(negedge CLK);
      chk("req_vld", 64'(o_mem_vld), 64'd1);
      chk("req_we", 64'(o_we), 64'(st));
      chk("req_be", 64'(o_be), e_be);
      chk("req_addr", 64'(o_addr), e_addr);
      if (st) chk("req_wdata", o_wdata, e_wd);
      chk("req_stall", 64'(o_stall), 64'd1);
      if (mode == 1 && k == fl_dly && k < rdy_dly) begin
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        chk("flushreq_vld", 64'(o_mem_vld), 64'd0);
        chk("flushreq_stall", 64'(o_stall), 64'd0);
        chk("flushreq_wb", 64'(o_wb_valid), 64'd0);
        return;
      end
    end
    mem_ready = 1'b1;
    flush = (mode == 3);
    @(negedge CLK);
    mem_ready = 1'b0;
    flush = 1'b0;
    chk("hs_vld_drop", 64'(o_mem_vld), 64'd0);
    if (st) begin
      chk("store_done_stall", 64'(o_stall), 64'd0);
      chk("store_no_wb", 64'(o_wb_valid), 64'd0);
      return;
    end
    dropped = (mode == 3);
    if (mode == 5 || mode == 6) begin
      for (int c = 0; c < 8; c++) begin
        chk("to_stall", 64'(o_stall), 64'd1);
        chk("to_early", 64'(o_berr), 64'd0);
        flush = (mode == 6 && c == fl_dly);
        rsp_data = {$urandom, $urandom};
        @(negedge CLK);
        flush = 1'b0;
      end
      chk("to_buserr", 64'(o_berr), 64'(mode == 5 && !dropped));
      if (mode == 5 && !dropped) chk("to_excaddr", 64'(o_exc_addr), 64'(ad));
      chk("to_idle", 64'(o_stall), 64'd0);
      chk("to_no_wb", 64'(o_wb_valid), 64'd0);
      rsp_valid = 1'b1;
      @(negedge CLK);
      rsp_valid = 1'b0;
      chk("late_rsp_wb", 64'(o_wb_valid), 64'd0);
      chk("late_rsp_berr", 64'(o_berr), 64'd0);
      return;
    end
    for (int c = 0; c < rsp_dly; c++) begin
      chk("wait_stall", 64'(o_stall), 64'd1);
      chk("wait_no_wb", 64'(o_wb_valid), 64'd0);
      flush = (mode == 2 && c == fl_dly);
      rsp_data = {$urandom, $urandom};
      @(negedge CLK);
      flush = 1'b0;
    end
    dropped = dropped || (mode == 2 && fl_dly < rsp_dly) || mode == 4;
    chk("rsp_stall", 64'(o_stall), 64'd1);
    rsp_valid = 1'b1;
    rsp_data = raw;
    flush = (mode == 4);
    @(negedge CLK);
    rsp_valid = 1'b0;
    flush = 1'b0;
    exp_wb = !dropped && rd != 5'd0;
    chk("wb_valid", 64'(o_wb_valid), 64'(exp_wb));
    if (exp_wb) begin
      chk("wb_rd", 64'(o_wb_rd), 64'(rd));
      chk("wb_data", o_wb_data, e_ld);
      last_wb = o_wb_data;
      last_rd = o_wb_rd;
    end
    chk("rsp_idle", 64'(o_stall), 64'd0);
    chk("rsp_berr", 64'(o_berr), 64'd0);
    @(negedge CLK);
    chk("wb_once", 64'(o_wb_valid), 64'd0);
  endtask

  initial begin
    #1;
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1;
      chk("rst_ready", 64'(o_req_ready), 64'd1);
      chk("rst_stall", 64'(o_stall), 64'd0);
      chk("rst_mem_vld", 64'(o_mem_vld), 64'd0);
      chk("rst_be", 64'(o_be), 64'd0);
      chk("rst_wb", 64'(o_wb_valid), 64'd0);
      chk("rst_exc", 64'(o_exc) | 64'(o_berr), 64'd0);
    end
    @(negedge CLK);
    RST_n = 1'b1;

    run_op(0, 0, 2'd0, 0, 32'h1001, '0, 5'd5, 64'h12F45678, 0, 1, 0, 0);
    chk("tp_lb_signed", last_wb, 64'hFFFFFFF4);
    run_op(0, 0, 2'd0, 1, 32'h1001, '0, 5'd7, 64'h12F45678, 0, 0, 0, 0);
    chk("tp_lbu", last_wb, 64'h000000F4);
    chk("tp_lbu_rd", 64'(last_rd), 64'd7);
    run_op(0, 1, 2'd1, 0, 32'h2002, 64'h0000ABCD, 5'd0, '0, 3, 0, 0, 0);
    chk("tp_sh_be", last_be, 64'h3);
    chk("tp_sh_wdata", last_wd, 64'h0000ABCD);
    chk("tp_sh_addr", last_addr, 64'h2000);
    run_op(0, 0, 2'd2, 0, 32'h3002, '0, 5'd1, '0, 0, 0, 0, 0);
    run_op(0, 0, 2'd3, 0, 32'h3000, '0, 5'd1, '0, 0, 0, 0, 0);
    run_op(0, 0, 2'd2, 0, 32'h4000, '0, 5'd3, '0, 1, 0, 5, 0);
    run_op(0, 0, 2'd2, 0, 32'h5004, '0, 5'd4, 64'h11223344, 0, 7, 2, 2);
    run_op(0, 0, 2'd2, 0, 32'h5008, '0, 5'd4, 64'h55667788, 0, 2, 0, 0);
    chk("tp_after_flush", last_wb, 64'h55667788);
    run_op(1, 0, 2'd1, 0, 32'h06, '0, 5'd9, 64'h8001_0000_0000_0000, 0, 1, 0, 0);
    chk("tp64_lh", last_wb, 64'hFFFF_FFFF_FFFF_8001);
    run_op(1, 1, 2'd0, 0, 32'h05, 64'hAA, 5'd0, '0, 0, 0, 0, 0);
    chk("tp64_sb_be", last_be, 64'h20);
    chk("tp64_sb_wdata", last_wd, 64'h0000_AA00_0000_0000);

    for (int it = 0; it < 300; it++) begin
      bit s, st, un;
      logic [1:0] sz;
      logic [31:0] ad;
      int rdy, rsp, mode, fl;
      s = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      un = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      ad = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 3) != 0) ad[2:0] = 3'($urandom_range(0, 7)) & ~3'((1 << sz) - 1);
      rdy = $urandom_range(0, 4);
      rsp = $urandom_range(0, 6);
      mode = $urandom_range(0, 6);
      fl = 0;
      if (mode == 1) begin if (rdy == 0) mode = 0; else fl = $urandom_range(0, rdy - 1); end
      if (mode == 2) begin if (rsp == 0) mode = 0; else fl = $urandom_range(0, rsp - 1); end
      if (mode == 6) fl = $urandom_range(0, 6);
      run_op(s, st, sz, un, ad, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
             {$urandom, $urandom}, rdy, rsp, mode, fl);
    end

    @(negedge CLK);
    sel = 1'b0; req_store = 1'b0; req_size = 2'd2; req_addr = 32'h40; req_rd = 5'd2;
    req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge CLK);
    mem_ready = 1'b0;
    RST_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(o_req_ready), 64'd1);
    chk("midrst_stall", 64'(o_stall), 64'd0);
    chk("midrst_vld", 64'(o_mem_vld), 64'd0);
    @(negedge CLK);
    RST_n = 1'b1;
    rsp_valid = 1'b1;
    @(negedge CLK);
    rsp_valid = 1'b0;
    chk("midrst_late_wb", 64'(o_wb_valid), 64'd0);
    chk("midrst_idle", 64'(o_stall), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
